// File: rtl/blink_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the LED-blink timer initiator.
//   - blink_state_e      : controller state encoding (2 bits)
//   - *_DEFAULT          : default timing constants (50 MHz system clock)
//   - BLINK_TICKS_EXPECTED : ticks the blinker consumes before it answers
//   - sat_inc8           : 8-bit saturating increment for the tick counter
// ---------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } blink_state_e;

    // 25_000_000 clocks = 0.5 s at 50 MHz.
    localparam int unsigned BLINK_TICK_DIV_DEFAULT  = 25000000;
    localparam int unsigned BLINK_CNT_W_DEFAULT     = 25;
    localparam int unsigned BLINK_MAX_TICKS_DEFAULT = 12;

    // The blinker answers with blink_timeout the cycle after this many ticks.
    localparam int unsigned BLINK_TICKS_EXPECTED    = 8;

    // Tick counter never wraps; a wrap could hide a stuck responder.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// ---------------------------------------------------------------------------
// blink_prescaler
// Free-running modulo-TICK_DIV counter with synchronous clear and enable.
// o_terminal is high for the single enabled cycle in which the count sits at
// TICK_DIV-1; the count wraps to 0 on that same edge.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high (count -> 0)
//   i_clear     synchronous clear (count -> 0), dominates enable
//   i_enable    advance the count this cycle
//   o_terminal  count == TICK_DIV-1 while enabled (combinational, 1 cycle)
// ---------------------------------------------------------------------------
module blink_prescaler #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last  = (r_count == LP_LAST);
    // Gated by enable so a held (paused) count at the last value cannot
    // produce repeated terminal pulses.
    assign o_terminal = i_enable && w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/blink_tick_ctrl.sv
// ---------------------------------------------------------------------------
// blink_tick_ctrl
// Initiator side of the LED-blink timer handshake. After start it emits a
// one-cycle tick every TICK_DIV clocks to the blinker, waits for the
// blinker's blink_timeout and reports done (one cycle) or, if more than
// MAX_TICKS ticks go unanswered, a sticky err.
//
// Handshake with the blinker: tick is a registered one-cycle strobe that the
// blinker counts; blink_timeout is sampled as a level every RUN cycle and the
// first high sample ends the run, so a long pulse yields a single done.
//
// Optional build macro: BLINK_PAUSE_EN adds input pause. While pause is high
// in RUN the prescaler and tick counter hold and no tick is issued; abort and
// blink_timeout are still honoured.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   start          begin a sequence (acted on in IDLE or ERR)
//   abort          cancel the running sequence / clear err
//   blink_timeout  completion level from the LED blinker
//   pause          (BLINK_PAUSE_EN only) freeze the tick timebase in RUN
//   tick           one-cycle timer pulse to the blinker (registered)
//   busy           high while in RUN
//   done           one-cycle completion pulse
//   err            watchdog fault, held until start or abort
//   dbg_state      current controller state (blink_state_e encoding)
// ---------------------------------------------------------------------------
module blink_tick_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned TICK_DIV  = BLINK_TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W     = BLINK_CNT_W_DEFAULT,
    parameter int unsigned MAX_TICKS = BLINK_MAX_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       blink_timeout,
`ifdef BLINK_PAUSE_EN
    input  logic       pause,
`endif
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam logic [7:0] LP_MAX_TICKS = 8'(MAX_TICKS);

    blink_state_e r_state;
    blink_state_e w_state_nxt;
    logic [7:0]   r_tick_count;
    logic         r_tick;

    logic         w_run;
    logic         w_pause;
    logic         w_presc_en;
    logic         w_presc_clr;
    logic         w_terminal;
    logic         w_watchdog;
    logic         w_tick_fire;

    assign w_run = (r_state == ST_RUN);

`ifdef BLINK_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // The timebase only advances in RUN; every other state holds it at 0,
    // which gives the clean restart from IDLE and from ERR for free.
    assign w_presc_en  = w_run && !w_pause;
    assign w_presc_clr = !w_run;

    blink_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_presc_clr),
        .i_enable   (w_presc_en),
        .o_terminal (w_terminal)
    );

    // MAX_TICKS ticks already went out unanswered and another period has
    // elapsed: the blinker is considered dead.
    assign w_watchdog = w_terminal && (r_tick_count >= LP_MAX_TICKS);

    // Next state and tick request. Priority in RUN: abort, then
    // blink_timeout, then watchdog, then the regular tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (blink_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (w_watchdog) begin
                    w_state_nxt = ST_ERR;
                end else if (w_terminal) begin
                    w_tick_fire = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                // abort wins over a simultaneous start: leaving the fault to
                // IDLE is the conservative choice.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tick       <= 1'b0;
            r_tick_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_fire;
            if (!w_run) begin
                r_tick_count <= 8'd0;
            end else if (w_tick_fire) begin
                r_tick_count <= sat_inc8(r_tick_count);
            end
        end
    end

    // All outputs decode registered state, so none of them glitch.
    assign tick      = r_tick;
    assign busy      = w_run;
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_ERR);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_blink_tick_ctrl.sv
module tb_blink_tick_ctrl;
    import blink_pkg::*;

    localparam int TD = 4;
    localparam int MT = 12;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst, start, abort, bt, pause;
    logic       tick, busy, done, err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    blink_tick_ctrl #(
        .TICK_DIV  (TD),
        .CNT_W     (3),
        .MAX_TICKS (MT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .blink_timeout (bt),
`ifdef BLINK_PAUSE_EN
        .pause         (pause),
`endif
        .tick          (tick),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .dbg_state     (dbg_state)
    );

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rc;                 // index of the cycle currently being driven

    // ---------------- reference model ----------------
    // Abstract view: a run is described only by how many un-paused RUN
    // cycles have elapsed (m_act). Every TD elapsed cycles a tick is due;
    // the (MT+1)-th due tick is the watchdog instead.
    blink_state_e m_phase;
    int           m_act;
    logic         m_tick;

    task automatic model_update(input logic s, input logic a, input logic b,
                                input logic p, input logic r);
        m_tick = 1'b0;
        if (r) begin
            m_phase = ST_IDLE;
            m_act   = 0;
        end else begin
            case (m_phase)
                ST_IDLE: if (s) begin m_phase = ST_RUN; m_act = 0; end
                ST_DONE: m_phase = ST_IDLE;
                ST_ERR: begin
                    if (a) m_phase = ST_IDLE;
                    else if (s) begin m_phase = ST_RUN; m_act = 0; end
                end
                default: begin
                    if (a) m_phase = ST_IDLE;
                    else if (b) m_phase = ST_DONE;
                    else if (!p) begin
                        m_act++;
                        if (m_act % TD == 0) begin
                            if (m_act / TD <= MT) m_tick = 1'b1;
                            else m_phase = ST_ERR;
                        end
                    end
                end
            endcase
        end
    endtask

    // ---------------- checkers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, rc);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, rc);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs for cycle rc, clock, then compare all outputs of cycle rc+1.
    task automatic step(input logic s, input logic a, input logic b,
                        input logic p, input logic r);
        start = s;
        abort = a;
        bt    = b;
        rst   = r;
`ifdef BLINK_PAUSE_EN
        pause = p;
`else
        pause = 1'b0;
`endif
        @(posedge clk);
        model_update(s, a, b, pause, r);
        #1;
        rc++;
        chk1("tick", tick, m_tick);
        chk1("busy", busy, m_phase == ST_RUN);
        chk1("done", done, m_phase == ST_DONE);
        chk1("err",  err,  m_phase == ST_ERR);
        chk2("state", dbg_state, m_phase);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_t, last_t, done_at, err_at, first_t, third_t;
        logic b, p;
        m_phase = ST_IDLE;
        m_act   = 0;
        m_tick  = 1'b0;
        rc      = 0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // 1. Nominal run with a responder that answers after 8 ticks
        rc = 0; n_t = 0; last_t = -10; done_at = -1; first_t = -1;
        step(1, 0, 0, 0, 0);
        while (rc < 40) begin
            b = (n_t == int'(BLINK_TICKS_EXPECTED)) && (rc == last_t + 1);
            step(0, 0, b, 0, 0);
            if (tick) begin
                if (n_t == 0) first_t = rc;
                n_t++;
                last_t = rc;
            end
            if (done && done_at < 0) done_at = rc;
        end
        chkn("s1_ticks", n_t, 8);
        chkn("s1_first_tick", first_t, 5);
        chkn("s1_last_tick", last_t, 33);
        chkn("s1_done_cycle", done_at, 35);

        // 2. blink_timeout in the cycle the prescaler is terminal
        rc = 0;
        step(1, 0, 0, 0, 0);
        while (rc < 8) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk1("s2_no_tick", tick, 1'b0);
        chk1("s2_done", done, 1'b1);
        repeat (3) step(0, 0, 0, 0, 0);

        // 3. Abort at cycle 10
        rc = 0; n_t = 0; done_at = -1;
        step(1, 0, 0, 0, 0);
        while (rc < 10) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk1("s3_idle", busy, 1'b0);
        repeat (20) begin
            step(0, 0, 0, 0, 0);
            if (tick) n_t++;
            if (done) done_at = rc;
        end
        chkn("s3_ticks_after", n_t, 0);
        chkn("s3_no_done", done_at, -1);

        // 4. Watchdog with a silent responder, then restart from ERR
        rc = 0; n_t = 0; err_at = -1;
        step(1, 0, 0, 0, 0);
        while (err_at < 0 && rc < 80) begin
            step(0, 0, 0, 0, 0);
            if (tick) n_t++;
            if (err) err_at = rc;
        end
        chkn("s4_ticks", n_t, MT);
        chkn("s4_err_cycle", err_at, 53);
        repeat (5) step(0, 0, 0, 0, 0);
        chk1("s4_err_held", err, 1'b1);
        step(1, 0, 0, 0, 0);
        chk1("s4_err_clr", err, 1'b0);
        chk1("s4_rerun", busy, 1'b1);
        step(0, 1, 0, 0, 0);

        // 5. Reset in mid-RUN, then a stray blink_timeout
        rc = 0;
        step(1, 0, 0, 0, 0);
        while (rc < 15) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk1("s5_busy", busy, 1'b0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk1("s5_no_done", done, 1'b0);

`ifdef BLINK_PAUSE_EN
        // 6. Pause for 10 cycles right after the 2nd tick
        rc = 0; n_t = 0; last_t = -10; third_t = -1;
        step(1, 0, 0, 0, 0);
        while (rc < 60) begin
            b = (n_t == int'(BLINK_TICKS_EXPECTED)) && (rc == last_t + 1);
            p = (rc >= 10) && (rc <= 19);
            step(0, 0, b, p, 0);
            if (tick) begin
                n_t++;
                if (n_t == 3) third_t = rc;
                last_t = rc;
            end
        end
        chkn("s6_third_tick", third_t, 23);
        chkn("s6_ticks", n_t, 8);
`endif

        // Random traffic, first with a chatty then with a quiet responder
        for (int seg = 0; seg < 2; seg++) begin
            repeat (1500) begin
                step($urandom_range(0, 7) == 0,
                     $urandom_range(0, 59) == 0,
                     (seg == 0) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 199) == 0),
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_tick_ctrl.md
Name: blink_tick_ctrl

Overview:
Initiator side of the LED-blink timer handshake.
- On `start`, generates the periodic one-cycle `tick` pulses that drive the LED blinker's `timer` input.
- Consumes the blinker's `timeout` pulse and reports completion (`done`) or a watchdog failure (`err`) to the game-level control FSM.
- Sits between the top-level sequencer and the LED blink responder.

Parameters:
- TICK_DIV, 25000000: clocks per tick period (0.5 s at 50 MHz); must be >= 2.
- CNT_W, 25: prescaler width; must satisfy 2^CNT_W >= TICK_DIV.
- MAX_TICKS, 12: watchdog limit on ticks issued without seeing `blink_timeout`; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a blink sequence; sampled in IDLE or ERR only.
- abort  in  1  cancel the running sequence.
- blink_timeout  in  1  completion pulse from the LED blinker.
- tick  out  1  one-cycle timer pulse to the blinker; registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  watchdog fault flag; sticky.

Behaviour:
Reset:
- `rst`=1 at a posedge forces IDLE: `tick`=0, `busy`=0, `done`=0, `err`=0, prescaler=0, tick_count=0.
- `rst` overrides every other input, including in mid-RUN. No `done` is issued on reset.

States: IDLE, RUN, DONE, ERR (2-bit encoding).

IDLE:
- `start`=1 -> RUN next cycle; prescaler and tick_count cleared.
- `abort` and `blink_timeout` are ignored.

RUN:
- `busy`=1.
- Prescaler counts 0..TICK_DIV-1 and wraps to 0.
- When the prescaler equals TICK_DIV-1, `tick`=1 on the next cycle only, and tick_count increments (8-bit, saturating).
- First `tick` occurs exactly TICK_DIV cycles after `busy` rises; subsequent ticks are every TICK_DIV cycles.
- `start` is ignored.

Priority in RUN, highest first:
1. `abort`: -> IDLE; no `done`; any pending tick is suppressed.
2. `blink_timeout`: -> DONE; a tick due in the same cycle is suppressed.
3. Watchdog: tick_count reaches MAX_TICKS and the prescaler hits terminal with no `blink_timeout` -> ERR.

DONE:
- `done`=1 and `busy`=0 for exactly one cycle, then -> IDLE unconditionally.
- `start` asserted during DONE is ignored.

ERR:
- `err`=1 held, `busy`=0, `tick`=0.
- `start` clears `err` and -> RUN (same clear rules as from IDLE).
- `abort` -> IDLE and clears `err`.

Other rules:
- `blink_timeout` is treated as a level sampled each cycle; a multi-cycle high causes only one DONE.
- Normal handshake with the blinker: 8 ticks issued, `blink_timeout` arrives the cycle after the 8th tick, `done` follows 1 cycle later.

Optional Feature:
- Macro: BLINK_PAUSE_EN.
- Defined: adds input port `pause` (1 bit). While `pause`=1 in RUN:
  - prescaler and tick_count hold;
  - no `tick` is generated;
  - `abort` and `blink_timeout` are still honoured.
- Undefined: no `pause` port; the prescaler runs freely in RUN.

Decomposition:
- Package blink_pkg:
  - state enum (ST_IDLE, ST_RUN, ST_DONE, ST_ERR);
  - default TICK_DIV / MAX_TICKS constants;
  - BLINK_TICKS_EXPECTED=8.
- Sub-module blink_prescaler:
  - inputs: CNT_W-bit counter with clear and enable;
  - output: one-cycle terminal pulse at TICK_DIV-1;
  - instantiated once.
- FSM, watchdog and output registers stay in blink_tick_ctrl.

Test Plan:
All scenarios run with TICK_DIV=4, MAX_TICKS=12.
1. Nominal run: `start` pulse at cycle 0 -> `busy`=1 from cycle 1; `tick` at cycles 5, 9, ..., 33 (8 ticks); responder model returns `blink_timeout` at 34 -> `done`=1 at 35; `busy`=0 at 35; IDLE at 36.
2. Timeout/tick collision: `blink_timeout` forced in the cycle the prescaler hits terminal -> no `tick` next cycle; `done` the cycle after.
3. Abort: `abort` at cycle 10 during RUN -> IDLE at 11; `done` never asserts; no further ticks.
4. Watchdog: responder silent -> 12 ticks, then `err`=1 at the next terminal; `err` holds; `start` -> `err`=0 and a new RUN begins.
5. Reset mid-RUN: `rst` at cycle 15 -> all outputs 0 at 16; a `blink_timeout` at 17 produces no `done`.
6. BLINK_PAUSE_EN defined: `pause` high for 10 cycles after the 2nd tick -> the 3rd tick is delayed by exactly 10 cycles; total tick count is unchanged.
